// File: rtl/pio_fifo_pair_if.sv
// Bus bundle for pio_fifo_pair: TX/RX push/pop handshakes, status, sticky flags and control.
// Threshold signals exist only when PIO_FIFO_THRESH_EN is defined.
`timescale 1ns/1ps

interface pio_fifo_pair_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(2*DEPTH) + 1;

    // "join" is a reserved word, so the storage-sharing select is join_sel.
    logic [1:0]       join_sel;
    logic             flush;
    logic             err_clr;

    logic             tx_push;
    logic [WIDTH-1:0] tx_din;
    logic             tx_pop;
    logic [WIDTH-1:0] tx_dout;
    logic             tx_empty;
    logic             tx_full;
    logic [CW-1:0]    tx_count;

    logic             rx_push;
    logic [WIDTH-1:0] rx_din;
    logic             rx_pop;
    logic [WIDTH-1:0] rx_dout;
    logic             rx_empty;
    logic             rx_full;
    logic [CW-1:0]    rx_count;

    logic             tx_overflow;
    logic             tx_underflow;
    logic             rx_overflow;
    logic             rx_underflow;

`ifdef PIO_FIFO_THRESH_EN
    logic [CW-1:0]    tx_thresh;
    logic [CW-1:0]    rx_thresh;
    logic             tx_low;
    logic             rx_high;
`endif

    modport master (
        output join_sel, flush, err_clr,
        output tx_push, tx_din, tx_pop, rx_push, rx_din, rx_pop,
        input  tx_dout, tx_empty, tx_full, tx_count,
        input  rx_dout, rx_empty, rx_full, rx_count,
        input  tx_overflow, tx_underflow, rx_overflow, rx_underflow
`ifdef PIO_FIFO_THRESH_EN
        ,
        output tx_thresh, rx_thresh,
        input  tx_low, rx_high
`endif
    );

    modport slave (
        input  join_sel, flush, err_clr,
        input  tx_push, tx_din, tx_pop, rx_push, rx_din, rx_pop,
        output tx_dout, tx_empty, tx_full, tx_count,
        output rx_dout, rx_empty, rx_full, rx_count,
        output tx_overflow, tx_underflow, rx_overflow, rx_underflow
`ifdef PIO_FIFO_THRESH_EN
        ,
        input  tx_thresh, rx_thresh,
        output tx_low, rx_high
`endif
    );
endinterface

// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair for one PIO state machine with join mode, sticky errors and flush.
// Optional threshold outputs (tx_low/rx_high) are built when PIO_FIFO_THRESH_EN is defined.
`timescale 1ns/1ps

module pio_fifo_pair #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pio_fifo_pair_if.slave bus
);
    localparam int AW = $clog2(2*DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] JOIN_NONE = 2'b00;
    localparam logic [1:0] JOIN_TX   = 2'b01;
    localparam logic [1:0] JOIN_RX   = 2'b10;

    localparam logic [CW-1:0] CAP_NONE = '0;
    localparam logic [CW-1:0] CAP_BANK = CW'(DEPTH);
    localparam logic [CW-1:0] CAP_JOIN = CW'(2*DEPTH);
    localparam logic [AW-1:0] BASE_B   = AW'(DEPTH);

    // Bank A is mem[0..DEPTH-1], bank B is mem[DEPTH..2*DEPTH-1]; a joined ring spans both.
    logic [WIDTH-1:0] mem [2*DEPTH];

    logic [1:0]    join_q,     join_d;
    logic [AW-1:0] tx_head_q,  tx_head_d;
    logic [AW-1:0] tx_tail_q,  tx_tail_d;
    logic [CW-1:0] tx_count_q, tx_count_d;
    logic [AW-1:0] rx_head_q,  rx_head_d;
    logic [AW-1:0] rx_tail_q,  rx_tail_d;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic          tx_ovf_q,   tx_ovf_d;
    logic          tx_udf_q,   tx_udf_d;
    logic          rx_ovf_q,   rx_ovf_d;
    logic          rx_udf_q,   rx_udf_d;

    logic [CW-1:0] tx_cap, rx_cap;
    logic [AW-1:0] rx_base;
    logic [AW-1:0] rx_waddr, rx_raddr;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_pop_ok, tx_push_ok, rx_pop_ok, rx_push_ok;
    logic          reconfig, hold;
    logic          tx_we, rx_we;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p, input logic [CW-1:0] cap);
        return ({1'b0, p} == cap - 1'b1) ? '0 : p + 1'b1;
    endfunction

    // Capacity and ring base of each direction follow the registered mode only.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        tx_cap  = CAP_BANK;
        rx_cap  = CAP_BANK;
        rx_base = BASE_B;
        case (join_q)
            JOIN_TX: begin
                tx_cap  = CAP_JOIN;
                rx_cap  = CAP_NONE;
                rx_base = '0;
            end
            JOIN_RX: begin
                tx_cap  = CAP_NONE;
                rx_cap  = CAP_JOIN;
                rx_base = '0;
            end
            default: ;
        endcase
    end

    assign rx_waddr = rx_base + rx_tail_q;
    assign rx_raddr = rx_base + rx_head_q;

    // A capacity-0 direction reads as both empty and full, so it rejects everything.
    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == tx_cap);
    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == rx_cap);

    assign tx_pop_ok  = bus.tx_pop & ~tx_empty;
    assign tx_push_ok = bus.tx_push & (~tx_full | tx_pop_ok);
    assign rx_pop_ok  = bus.rx_pop & ~rx_empty;
    assign rx_push_ok = bus.rx_push & (~rx_full | rx_pop_ok);

    // A mode change or flush clears both FIFOs and swallows that cycle's traffic.
    assign reconfig = (bus.join_sel != join_q);
    assign hold     = reconfig | bus.flush;
    assign tx_we    = tx_push_ok & ~hold;
    assign rx_we    = rx_push_ok & ~hold;

    always_comb begin
        join_d     = bus.join_sel;
        tx_head_d  = tx_head_q;
        tx_tail_d  = tx_tail_q;
        tx_count_d = tx_count_q;
        rx_head_d  = rx_head_q;
        rx_tail_d  = rx_tail_q;
        rx_count_d = rx_count_q;
        if (hold) begin
            tx_head_d  = '0;
            tx_tail_d  = '0;
            tx_count_d = '0;
            rx_head_d  = '0;
            rx_tail_d  = '0;
            rx_count_d = '0;
        end else begin
            if (tx_pop_ok)  tx_head_d = ptr_inc(tx_head_q, tx_cap);
            if (tx_push_ok) tx_tail_d = ptr_inc(tx_tail_q, tx_cap);
            tx_count_d = tx_count_q + CW'(tx_push_ok) - CW'(tx_pop_ok);
            if (rx_pop_ok)  rx_head_d = ptr_inc(rx_head_q, rx_cap);
            if (rx_push_ok) rx_tail_d = ptr_inc(rx_tail_q, rx_cap);
            rx_count_d = rx_count_q + CW'(rx_push_ok) - CW'(rx_pop_ok);
        end
    end

    // Sticky flags: a same-cycle error event beats err_clr.
    always_comb begin
        tx_ovf_d = (tx_ovf_q & ~bus.err_clr) | (~hold & bus.tx_push & ~tx_push_ok);
        tx_udf_d = (tx_udf_q & ~bus.err_clr) | (~hold & bus.tx_pop  & tx_empty);
        rx_ovf_d = (rx_ovf_q & ~bus.err_clr) | (~hold & bus.rx_push & ~rx_push_ok);
        rx_udf_d = (rx_udf_q & ~bus.err_clr) | (~hold & bus.rx_pop  & rx_empty);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            join_q     <= JOIN_NONE;
            tx_head_q  <= '0;
            tx_tail_q  <= '0;
            tx_count_q <= '0;
            rx_head_q  <= '0;
            rx_tail_q  <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            tx_udf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
        end else begin
            join_q     <= join_d;
            tx_head_q  <= tx_head_d;
            tx_tail_q  <= tx_tail_d;
            tx_count_q <= tx_count_d;
            rx_head_q  <= rx_head_d;
            rx_tail_q  <= rx_tail_d;
            rx_count_q <= rx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            tx_udf_q   <= tx_udf_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_udf_q   <= rx_udf_d;
        end
    end

    // NOTE: storage is not reset; dout is gated by empty, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (tx_we) mem[tx_tail_q] <= bus.tx_din;
        if (rx_we) mem[rx_waddr]  <= bus.rx_din;
    end

    assign bus.tx_dout      = tx_empty ? '0 : mem[tx_head_q];
    assign bus.rx_dout      = rx_empty ? '0 : mem[rx_raddr];
    assign bus.tx_empty     = tx_empty;
    assign bus.tx_full      = tx_full;
    assign bus.tx_count     = tx_count_q;
    assign bus.rx_empty     = rx_empty;
    assign bus.rx_full      = rx_full;
    assign bus.rx_count     = rx_count_q;
    assign bus.tx_overflow  = tx_ovf_q;
    assign bus.tx_underflow = tx_udf_q;
    assign bus.rx_overflow  = rx_ovf_q;
    assign bus.rx_underflow = rx_udf_q;

`ifdef PIO_FIFO_THRESH_EN
    assign bus.tx_low  = (tx_cap != CAP_NONE) && (tx_count_q <  bus.tx_thresh);
    assign bus.rx_high = (rx_cap != CAP_NONE) && (rx_count_q >= bus.rx_thresh);
`endif
endmodule
